fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch slice: machine width, fetch FSM states,
// reset PC default and a word-alignment helper.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding {pc, instruction} pairs; the head entry
// stays put until popped, and flush empties it in one cycle.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q,  count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one outstanding memory request at a time,
// buffers responses in a 2-entry FIFO and handles redirects with stale-response flushing.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc,
  output logic            misaligned
);

  localparam logic [1:0] FIFO_FULL = 2'(FIFO_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            misaligned_q, misaligned_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic [1:0]        fifo_count;
  logic [2*XLEN-1:0] fifo_rdata;
  logic              req_fire;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    misaligned_d   = 1'b0;
    fifo_push      = 1'b0;
    fifo_flush     = 1'b0;
    imem_req_valid = rst_n && (state_q == FETCH_IDLE) && (fifo_count < FIFO_FULL)
                     && !redirect_valid;
    req_fire       = imem_req_valid && imem_req_ready;
    fifo_pop       = instr_valid && instr_ready && !redirect_valid;

    if (redirect_valid) begin
      fifo_flush   = 1'b1;
      pc_d         = align_word(redirect_pc);
      misaligned_d = |redirect_pc[1:0];
      // A response landing with the redirect retires the outstanding request,
      // so only an unanswered request leaves us waiting in FLUSH.
      unique case (state_q)
        FETCH_WAIT, FETCH_FLUSH: state_d = imem_rsp_valid ? FETCH_IDLE : FETCH_FLUSH;
        default:                 state_d = FETCH_IDLE;
      endcase
    end else begin
      unique case (state_q)
        FETCH_IDLE: begin
          if (req_fire) begin
            pc_d     = pc_q + XLEN'(4);
            req_pc_d = pc_q;
            state_d  = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            fifo_push = 1'b1;
            state_d   = FETCH_IDLE;
          end
        end
        FETCH_FLUSH: begin
          if (imem_rsp_valid) begin
            state_d = FETCH_IDLE;
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  fetch_fifo #(
    .WIDTH(2 * XLEN)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_data({req_pc_q, imem_rsp_data}),
    .pop      (fifo_pop),
    .pop_data (fifo_rdata),
    .count    (fifo_count)
  );

  assign imem_req_addr = pc_q;
  assign instr_valid   = (fifo_count != 2'd0);
  assign instruction   = fifo_rdata[XLEN-1:0];
  assign instr_pc      = fifo_rdata[2*XLEN-1:XLEN];
  assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for the streaming/redirect path
// plus hand sequences for back-pressure, FIFO flush and reset during WAIT.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_ready, imem_rsp_valid, redirect_valid, instr_ready;
  logic [31:0] imem_rsp_data, redirect_pc;
  logic        imem_req_valid, instr_valid, misaligned;
  logic [31:0] imem_req_addr, instruction, instr_pc;
  logic        u2_req_valid, u2_instr_valid, u2_misaligned;
  logic [31:0] u2_req_addr, u2_instruction, u2_instr_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruction(instruction),
    .instr_pc(instr_pc), .misaligned(misaligned)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(u2_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(u2_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(u2_instr_valid),
    .instr_ready(instr_ready), .instruction(u2_instruction),
    .instr_pc(u2_instr_pc), .misaligned(u2_misaligned)
  );

  typedef struct {
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        redir;
    logic [31:0] rpc;
    logic        ir;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and settle before sampling.
  task automatic step(input logic rst, input logic rdy, input logic rspv,
                      input logic [31:0] rspd, input logic redir,
                      input logic [31:0] rpc, input logic ir);
    @(negedge clk);
    rst_n          = rst;
    imem_req_ready = rdy;
    imem_rsp_valid = rspv;
    imem_rsp_data  = rspd;
    redirect_valid = redir;
    redirect_pc    = rpc;
    instr_ready    = ir;
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check("rst reqv",  {31'd0, imem_req_valid}, 32'd0);
    check("rst iv",    {31'd0, instr_valid},    32'd0);
    check("rst mis",   {31'd0, misaligned},     32'd0);
    check("rst instr", instruction,             32'd0);
    check("rst ipc",   instr_pc,                32'd0);
    check("rst addr",  imem_req_addr,           32'd0);
    check("rst addr2", u2_req_addr,             32'hFFFF_FFFC);
    rst_n = 1'b1;
    #1;
    check("first req", {31'd0, imem_req_valid}, 32'd1);
  endtask

  initial begin
    //          rdy   rspv  rspd          redir rpc        ir     reqv  addr        iv    ipc         instr         mis
    tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,     1'b1,  1'b1, 32'h0,      1'b0, 32'h0,      32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b1, 32'h1111_0000,1'b0, 32'h0,     1'b1,  1'b0, 32'h4,      1'b0, 32'h0,      32'h0,        1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,     1'b1,  1'b1, 32'h4,      1'b1, 32'h0,      32'h1111_0000,1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'h2222_0004,1'b0, 32'h0,     1'b1,  1'b0, 32'h8,      1'b0, 32'h0,      32'h0,        1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,     1'b1,  1'b1, 32'h8,      1'b1, 32'h4,      32'h2222_0004,1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h100,   1'b1,  1'b0, 32'hC,      1'b0, 32'h0,      32'h0,        1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'hDEAD_0008,1'b0, 32'h0,     1'b1,  1'b0, 32'h100,    1'b0, 32'h0,      32'h0,        1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,     1'b1,  1'b1, 32'h100,    1'b0, 32'h0,      32'h0,        1'b0};
    tbl[8]  = '{1'b1, 1'b1, 32'h3333_0100,1'b0, 32'h0,     1'b1,  1'b0, 32'h104,    1'b0, 32'h0,      32'h0,        1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,     1'b1,  1'b1, 32'h104,    1'b1, 32'h100,    32'h3333_0100,1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'hDEAD_0104,1'b1, 32'h102,   1'b1,  1'b0, 32'h108,    1'b0, 32'h0,      32'h0,        1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     1'b1,  1'b1, 32'h100,    1'b0, 32'h0,      32'h0,        1'b1};
    tbl[12] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,     1'b1,  1'b1, 32'h100,    1'b0, 32'h0,      32'h0,        1'b0};
    tbl[13] = '{1'b1, 1'b1, 32'h4444_0100,1'b0, 32'h0,     1'b1,  1'b0, 32'h104,    1'b0, 32'h0,      32'h0,        1'b0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     1'b0,  1'b1, 32'h104,    1'b1, 32'h100,    32'h4444_0100,1'b0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     1'b1,  1'b1, 32'h104,    1'b1, 32'h100,    32'h4444_0100,1'b0};
    tbl[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     1'b0,  1'b1, 32'h104,    1'b0, 32'h0,      32'h0,        1'b0};

    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, tbl[i].rdy, tbl[i].rspv, tbl[i].rspd, tbl[i].redir, tbl[i].rpc, tbl[i].ir);
      check($sformatf("row%0d reqv", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].e_reqv});
      check($sformatf("row%0d addr", i), imem_req_addr,           tbl[i].e_addr);
      check($sformatf("row%0d iv", i),   {31'd0, instr_valid},    {31'd0, tbl[i].e_iv});
      check($sformatf("row%0d mis", i),  {31'd0, misaligned},     {31'd0, tbl[i].e_mis});
      if (tbl[i].e_iv) begin
        check($sformatf("row%0d ipc", i),   instr_pc,    tbl[i].e_ipc);
        check($sformatf("row%0d instr", i), instruction, tbl[i].e_instr);
      end
      if (i == 0) check("wrap first addr", u2_req_addr, 32'hFFFF_FFFC);
      if (i == 2) begin
        check("wrap second addr", u2_req_addr, 32'h0000_0000);
        check("wrap second reqv", {31'd0, u2_req_valid}, 32'd1);
        check("wrap ipc", u2_instr_pc, 32'hFFFF_FFFC);
      end
    end

    // Decoder stalled: two entries fill, then issue stops.
    do_reset();
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hAAAA_0000, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hBBBB_0004, 1'b0, '0, 1'b0);
    for (int c = 0; c < 6; c++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    check("stall reqv", {31'd0, imem_req_valid}, 32'd0);
    check("stall iv",   {31'd0, instr_valid},    32'd1);
    check("stall ipc",  instr_pc,                32'h0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("drain0 ipc",   instr_pc,    32'h0);
    check("drain0 instr", instruction, 32'hAAAA_0000);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("drain1 ipc",   instr_pc,    32'h4);
    check("drain1 instr", instruction, 32'hBBBB_0004);
    check("drain1 reqv",  {31'd0, imem_req_valid}, 32'd1);
    check("drain1 addr",  imem_req_addr, 32'h8);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check("drain2 iv", {31'd0, instr_valid}, 32'd0);

    // Redirect with a full buffer empties it.
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hCCCC_0008, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hDDDD_000C, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h300, 1'b0);
    check("flush pre iv",  {31'd0, instr_valid}, 32'd1);
    check("flush pre ipc", instr_pc, 32'h8);
    check("flush reqv",    {31'd0, imem_req_valid}, 32'd0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check("flush post iv", {31'd0, instr_valid}, 32'd0);
    check("flush addr",    imem_req_addr, 32'h300);
    check("flush reqv2",   {31'd0, imem_req_valid}, 32'd1);

    // Reset while WAIT; the late response must be dropped.
    do_reset();
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    check("rw req", imem_req_addr, 32'h0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    check("rw rst reqv", {31'd0, imem_req_valid}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'hDEAD_0000, 1'b0, '0, 1'b1);
    check("rw idle reqv", {31'd0, imem_req_valid}, 32'd1);
    check("rw idle addr", imem_req_addr, 32'h0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("rw dropped iv", {31'd0, instr_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h7777_0000, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("rw iv",    {31'd0, instr_valid}, 32'd1);
    check("rw ipc",   instr_pc,    32'h0);
    check("rw instr", instruction, 32'h7777_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
